// File: rtl/spm_pkg.sv
// spm_pkg: shared widths, ex bus field offsets and engine states
// for the scratchpad DMA engine.
package spm_pkg;
  localparam int A_W      = 8;
  localparam int D_W      = 32;
  localparam int NBG      = 4;
  localparam int BEAT_W   = NBG * D_W;
  localparam int EX_IN_W  = 168;
  localparam int EX_OUT_W = 128;
  localparam int WEN_LSB  = 164;
  localparam int REN_LSB  = 160;
  localparam int ADDR_LSB = 128;
  localparam int DATA_LSB = 0;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE,
    DRAIN,
    DONE
  } state_t;

  typedef logic [A_W-1:0]    addr_t;
  typedef logic [A_W:0]      len_t;
  typedef logic [NBG-1:0]    mask_t;
  typedef logic [BEAT_W-1:0] beat_t;

  function automatic beat_t lane_bits(input mask_t m);
    beat_t b;
    for (int i = 0; i < NBG; i++)
      b[i*D_W +: D_W] = {D_W{m[i]}};
    return b;
  endfunction
endpackage

// File: rtl/spm_dma_engine_if.sv
// spm_dma_engine_if: host command/stream handshakes plus the
// scratchpad external port seen by the DMA engine.
interface spm_dma_engine_if;
  import spm_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_dir;
  mask_t               cmd_mask;
  addr_t               cmd_base;
  len_t                cmd_len;
  logic                wr_valid;
  logic                wr_ready;
  beat_t               wr_data;
  logic                rd_valid;
  logic                rd_ready;
  beat_t               rd_data;
  logic [EX_IN_W-1:0]  ex_in_bus;
  logic [EX_OUT_W-1:0] ex_out_bus;
  logic                busy;
  logic                done;

  modport slave (
    input  cmd_valid, cmd_dir, cmd_mask,
    input  cmd_base, cmd_len,
    input  wr_valid, wr_data, rd_ready,
    input  ex_out_bus,
    output cmd_ready, wr_ready, rd_valid,
    output rd_data, ex_in_bus, busy, done
  );

  modport master (
    output cmd_valid, cmd_dir, cmd_mask,
    output cmd_base, cmd_len,
    output wr_valid, wr_data, rd_ready,
    output ex_out_bus,
    input  cmd_ready, wr_ready, rd_valid,
    input  rd_data, ex_in_bus, busy, done
  );
endinterface

// File: rtl/spm_rd_fifo.sv
// spm_rd_fifo: first-word-fall-through read-return buffer with an
// occupancy count used for read credit accounting.
module spm_rd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 128,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic          full, do_push, do_pop;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= inc(wp);
      if (do_pop)  rp <= inc(rp);
      count <= count + CNT_W'(do_push)
                     - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end
endmodule

// File: rtl/spm_dma_engine.sv
// spm_dma_engine: one-command-at-a-time LOAD/STORE initiator on the
// scratchpad external port, with credit-limited read returns.
module spm_dma_engine
  import spm_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             rst,
  spm_dma_engine_if.slave dma
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OCC_W = $clog2(FIFO_DEPTH + RD_LAT + 2);
  localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(FIFO_DEPTH);

  state_t             st, st_n;
  mask_t              mask_q, mask_n;
  addr_t              cur_q, cur_n;
  len_t               cnt_q, cnt_n;
  logic [EX_IN_W-1:0] ex_q, ex_n;
  logic [RD_LAT:0]    pipe_q;
  logic               rdy_q;
  logic               wr_go, rd_go;
  logic               push, pop, f_empty;
  logic [CNT_W-1:0]   f_cnt;
  logic [OCC_W-1:0]   inflight, occ;
  beat_t              f_dout;

  // pipe_q[k] marks a read whose ren was on the bus k cycles ago
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= RD_LAT; i++)
      inflight = inflight + OCC_W'(pipe_q[i]);
  end

  assign occ  = inflight + OCC_W'(f_cnt);
  assign push = pipe_q[RD_LAT];
  assign pop  = dma.rd_valid && dma.rd_ready;

  spm_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (BEAT_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (dma.ex_out_bus & lane_bits(mask_q)),
    .pop   (pop),
    .dout  (f_dout),
    .empty (f_empty),
    .count (f_cnt)
  );

  always_comb begin
    st_n   = st;
    mask_n = mask_q;
    cur_n  = cur_q;
    cnt_n  = cnt_q;
    wr_go  = 1'b0;
    rd_go  = 1'b0;
    unique case (st)
      IDLE: begin
        if (rdy_q && dma.cmd_valid) begin
          mask_n = dma.cmd_mask;
          cur_n  = dma.cmd_base;
          cnt_n  = dma.cmd_len;
          // an empty command still spends one busy cycle
          if (dma.cmd_len == '0) st_n = DRAIN;
          else if (dma.cmd_dir)  st_n = STORE;
          else                   st_n = LOAD;
        end
      end
      LOAD: begin
        if (dma.wr_valid) begin
          wr_go = 1'b1;
          cur_n = cur_q + addr_t'(1);
          cnt_n = cnt_q - len_t'(1);
          if (cnt_q == len_t'(1)) st_n = DONE;
        end
      end
      STORE: begin
        if (occ < DEPTH_C) begin
          rd_go = 1'b1;
          cur_n = cur_q + addr_t'(1);
          cnt_n = cnt_q - len_t'(1);
          if (cnt_q == len_t'(1)) st_n = DRAIN;
        end
      end
      DRAIN: begin
        if (inflight == '0 &&
            (f_empty ||
             (f_cnt == CNT_W'(1) && pop)))
          st_n = DONE;
      end
      DONE:    st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end

  always_comb begin
    ex_n = '0;
    for (int i = 0; i < NBG; i++) begin
      ex_n[WEN_LSB+i] = wr_go & mask_q[i];
      ex_n[REN_LSB+i] = rd_go & mask_q[i];
      if ((wr_go | rd_go) & mask_q[i])
        ex_n[ADDR_LSB+i*A_W +: A_W] = cur_q;
      if (wr_go & mask_q[i])
        ex_n[DATA_LSB+i*D_W +: D_W] =
          dma.wr_data[i*D_W +: D_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st     <= IDLE;
      mask_q <= '0;
      cur_q  <= '0;
      cnt_q  <= '0;
      ex_q   <= '0;
      pipe_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      st     <= st_n;
      mask_q <= mask_n;
      cur_q  <= cur_n;
      cnt_q  <= cnt_n;
      ex_q   <= ex_n;
      pipe_q[0] <= rd_go;
      for (int i = 1; i <= RD_LAT; i++)
        pipe_q[i] <= pipe_q[i-1];
      rdy_q  <= (st_n == IDLE);
    end
  end

  assign dma.cmd_ready = rdy_q;
  assign dma.wr_ready  = (st == LOAD);
  assign dma.rd_valid  = !f_empty &&
                         (st == STORE || st == DRAIN);
  assign dma.rd_data   = dma.rd_valid ? f_dout : '0;
  assign dma.ex_in_bus = ex_q;
  assign dma.busy      = (st == LOAD) || (st == STORE) ||
                         (st == DRAIN);
  assign dma.done      = (st == DONE);
endmodule

// File: tb/tb_spm_dma_engine.sv
// tb_spm_dma_engine: directed bench for spm_dma_engine against a
// fixed-pattern scratchpad model with one cycle read latency.
module tb_spm_dma_engine;
  import spm_pkg::*;

  localparam int FD = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  spm_dma_engine_if dif();

  spm_dma_engine #(
    .RD_LAT     (1),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .dma (dif)
  );

  typedef struct {
    int           cyc;
    logic [3:0]   en;
    logic [31:0]  addr;
    logic [127:0] data;
  } ev_t;

  ev_t wr_log[$];
  ev_t rd_log[$];
  ev_t beat_log[$];
  int  done_log[$];
  int  cyc = 0;
  int  n_chk = 0;
  int  n_fail = 0;
  int  issued, taken, max_out, wrdy_cnt;
  ev_t e;
  logic [127:0] spm_r;

  function automatic logic [31:0] pat(input int lane,
                                      input logic [7:0] a);
    return {4'hD, 4'(lane), 8'h00, a ^ 8'h5A, a};
  endfunction

  function automatic logic [127:0] beat(input int k);
    logic [127:0] b;
    for (int i = 0; i < 4; i++)
      b[32*i +: 32] = 32'hC0DE_0000 + 32'(i * 256 + k);
    return b;
  endfunction

  // scratchpad model: read data appears the cycle after ren
  always @(posedge clk) begin
    spm_r = '0;
    for (int i = 0; i < 4; i++)
      if (dif.ex_in_bus[REN_LSB+i])
        spm_r[32*i +: 32] =
          pat(i, dif.ex_in_bus[ADDR_LSB+8*i +: 8]);
    dif.ex_out_bus <= spm_r;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      e.cyc  = cyc;
      e.addr = dif.ex_in_bus[159:128];
      e.data = dif.ex_in_bus[127:0];
      if (dif.ex_in_bus[167:164] != 4'h0) begin
        e.en = dif.ex_in_bus[167:164];
        wr_log.push_back(e);
      end
      if (dif.ex_in_bus[163:160] != 4'h0) begin
        e.en = dif.ex_in_bus[163:160];
        rd_log.push_back(e);
        issued++;
      end
      if (dif.rd_valid && dif.rd_ready) begin
        e.en   = 4'h0;
        e.addr = '0;
        e.data = dif.rd_data;
        beat_log.push_back(e);
        taken++;
      end
      if (issued - taken > max_out)
        max_out = issued - taken;
      if (dif.done) done_log.push_back(cyc);
      if (dif.wr_ready) wrdy_cnt++;
    end
  end

  task automatic chk(input string tag,
                     input logic [167:0] got,
                     input logic [167:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_log.delete();
    rd_log.delete();
    beat_log.delete();
    done_log.delete();
    issued   = 0;
    taken    = 0;
    max_out  = 0;
    wrdy_cnt = 0;
  endtask

  task automatic send_cmd(input logic dir,
                          input logic [3:0] m,
                          input logic [7:0] b,
                          input logic [8:0] l,
                          output int hs);
    int k = 0;
    while (!dif.cmd_ready && k < 20) begin
      tick();
      k++;
    end
    chk("cmd_ready_wait", dif.cmd_ready, 1);
    dif.cmd_valid = 1'b1;
    dif.cmd_dir   = dir;
    dif.cmd_mask  = m;
    dif.cmd_base  = b;
    dif.cmd_len   = l;
    hs = cyc;
    tick();
    dif.cmd_valid = 1'b0;
  endtask

  task automatic load_beats(input int n);
    int   k = 0;
    int   g = 0;
    logic acc;
    while (k < n && g < 50) begin
      @(negedge clk);
      acc = dif.wr_ready & dif.wr_valid;
      tick();
      g++;
      if (acc) begin
        k++;
        dif.wr_data = beat(k);
      end
    end
    dif.wr_valid = 1'b0;
    chk("ld_beats_taken", k, n);
  endtask

  task automatic wait_done(input int max);
    int k = 0;
    while (done_log.size() == 0 && k < max) begin
      tick();
      k++;
    end
    chk("done_seen", done_log.size() > 0, 1);
    chk("ready_after_done", dif.cmd_ready, 1);
    tick();
    tick();
    chk("done_once", done_log.size(), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int           hs, d, g;
    logic [7:0]   a;
    logic [3:0]   pt;
    logic [127:0] m01;
    dif.cmd_valid = 1'b0;
    dif.cmd_dir   = 1'b0;
    dif.cmd_mask  = '0;
    dif.cmd_base  = '0;
    dif.cmd_len   = '0;
    dif.wr_valid  = 1'b0;
    dif.wr_data   = '0;
    dif.rd_ready  = 1'b0;
    clear_logs();

    // reset state
    tick();
    tick();
    @(negedge clk);
    chk("rst_cmd_ready", dif.cmd_ready, 0);
    chk("rst_flags", {dif.busy, dif.done, dif.wr_ready,
                      dif.rd_valid}, 0);
    chk("rst_ex_in", dif.ex_in_bus, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();
    @(negedge clk);
    chk("rel_cmd_ready", dif.cmd_ready, 1);
    tick();

    // wr_valid offered while idle is ignored
    clear_logs();
    dif.wr_valid = 1'b1;
    dif.wr_data  = beat(77);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_wr_ready", dif.wr_ready, 0);
      tick();
    end
    chk("idle_no_wen", wr_log.size(), 0);

    // LOAD base 0x10, len 4, full mask
    clear_logs();
    dif.wr_data = beat(0);
    send_cmd(1'b0, 4'hF, 8'h10, 9'd4, hs);
    load_beats(4);
    wait_done(20);
    chk("ld_nwr", wr_log.size(), 4);
    for (int k = 0; k < wr_log.size() && k < 4; k++) begin
      a = 8'h10 + 8'(k);
      chk("ld_wen", wr_log[k].en, 4'hF);
      chk("ld_addr", wr_log[k].addr, {4{a}});
      chk("ld_data", wr_log[k].data, beat(k));
      chk("ld_cyc", wr_log[k].cyc, hs + 2 + k);
    end
    d = (done_log.size() > 0) ? done_log[0] : -1;
    chk("ld_done_cyc", d, hs + 5);
    chk("ld_no_ren", rd_log.size(), 0);

    // STORE base 0xFE, len 3, mask 0x5, wr_valid held
    clear_logs();
    dif.wr_valid = 1'b1;
    dif.rd_ready = 1'b1;
    send_cmd(1'b1, 4'h5, 8'hFE, 9'd3, hs);
    wait_done(30);
    dif.wr_valid = 1'b0;
    chk("st_nren", rd_log.size(), 3);
    for (int k = 0; k < rd_log.size() && k < 3; k++) begin
      a = 8'hFE + 8'(k);
      chk("st_ren", rd_log[k].en, 4'h5);
      chk("st_addr", rd_log[k].addr,
          {8'h00, a, 8'h00, a});
      chk("st_ren_cyc", rd_log[k].cyc, hs + 2 + k);
    end
    chk("st_nbeat", beat_log.size(), 3);
    for (int k = 0; k < beat_log.size() && k < 3; k++) begin
      a = 8'hFE + 8'(k);
      chk("st_data", beat_log[k].data,
          {32'h0, pat(2, a), 32'h0, pat(0, a)});
    end
    if (beat_log.size() == 3) begin
      chk("st_first_lat", beat_log[0].cyc, hs + 4);
      d = (done_log.size() > 0) ? done_log[0] : -1;
      chk("st_done_cyc", d, beat_log[2].cyc + 1);
    end
    chk("st_wr_ready", wrdy_cnt, 0);
    chk("st_no_wen", wr_log.size(), 0);

    // STORE len 16 with rd_ready pattern 1-0-0-1
    clear_logs();
    send_cmd(1'b1, 4'hF, 8'h40, 9'd16, hs);
    pt = 4'b1001;
    g  = 0;
    while (done_log.size() == 0 && g < 300) begin
      dif.rd_ready = pt[g % 4];
      tick();
      g++;
    end
    dif.rd_ready = 1'b1;
    wait_done(10);
    chk("st16_nren", rd_log.size(), 16);
    for (int k = 0; k < rd_log.size() && k < 16; k++) begin
      a = 8'h40 + 8'(k);
      chk("st16_addr", rd_log[k].addr, {4{a}});
    end
    chk("st16_nbeat", beat_log.size(), 16);
    for (int k = 0; k < beat_log.size() && k < 16; k++) begin
      a = 8'h40 + 8'(k);
      chk("st16_data", beat_log[k].data,
          {pat(3, a), pat(2, a), pat(1, a), pat(0, a)});
    end
    chk("st16_outstanding", max_out <= FD, 1);

    // zero-length command
    clear_logs();
    send_cmd(1'b0, 4'hF, 8'h20, 9'd0, hs);
    @(negedge clk);
    chk("z_busy1", dif.busy, 1);
    chk("z_done1", dif.done, 0);
    @(negedge clk);
    chk("z_done2", dif.done, 1);
    chk("z_busy2", dif.busy, 0);
    @(negedge clk);
    chk("z_ready3", dif.cmd_ready, 1);
    chk("z_done3", dif.done, 0);
    chk("z_no_bus", wr_log.size() + rd_log.size(), 0);
    tick();

    // STORE with empty mask returns zero beats
    clear_logs();
    dif.rd_ready = 1'b1;
    send_cmd(1'b1, 4'h0, 8'h30, 9'd2, hs);
    wait_done(20);
    chk("m0_no_ren", rd_log.size(), 0);
    chk("m0_nbeat", beat_log.size(), 2);
    for (int k = 0; k < beat_log.size() && k < 2; k++)
      chk("m0_data", beat_log[k].data, 0);

    // reset mid-STORE with two reads in flight
    clear_logs();
    dif.rd_ready = 1'b0;
    send_cmd(1'b1, 4'hF, 8'h50, 9'd8, hs);
    tick();
    tick();
    @(negedge clk);
    #1;
    chk("pre_rst_issued", issued, 2);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_flags",
        {dif.cmd_ready, dif.wr_ready, dif.rd_valid,
         dif.busy, dif.done}, 0);
    chk("mid_rst_rd_data", dif.rd_data, 0);
    chk("mid_rst_ex_in", dif.ex_in_bus, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    clear_logs();
    tick();
    @(negedge clk);
    chk("rel2_ready", dif.cmd_ready, 1);
    chk("rel2_rd_valid", dif.rd_valid, 0);
    tick();
    tick();
    chk("rel2_no_beats", beat_log.size(), 0);

    // LOAD after reset, lanes 0-1 only
    clear_logs();
    dif.wr_valid = 1'b1;
    dif.wr_data  = beat(0);
    send_cmd(1'b0, 4'h3, 8'h80, 9'd2, hs);
    load_beats(2);
    wait_done(20);
    m01 = {64'h0, {64{1'b1}}};
    chk("ld2_nwr", wr_log.size(), 2);
    for (int k = 0; k < wr_log.size() && k < 2; k++) begin
      a = 8'h80 + 8'(k);
      chk("ld2_wen", wr_log[k].en, 4'h3);
      chk("ld2_addr", wr_log[k].addr,
          {8'h00, 8'h00, a, a});
      chk("ld2_data", wr_log[k].data, beat(k) & m01);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
